// File: rtl/pla_in4_pkg.sv
// Shared types and helpers for the in4 PLA decoder and its response buffer.
// PLA_IN4_RESP_PARITY_EN widens each stored entry by one even-parity bit.
package pla_in4_pkg;

  localparam int Z_WIDTH = 20;

  typedef logic [Z_WIDTH-1:0] z_vec_t;

`ifdef PLA_IN4_RESP_PARITY_EN
  localparam int ENTRY_W = Z_WIDTH + 1;
`else
  localparam int ENTRY_W = Z_WIDTH;
`endif

  function automatic logic z_parity(input z_vec_t z);
    return ^z;
  endfunction

endpackage

// File: rtl/pla_in4_resp_mem.sv
// DEPTH x WIDTH register array for the response buffer: one write port and
// one asynchronous read port. Contents are deliberately not reset.
module pla_in4_resp_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/pla_in4_resp_buffer.sv
// Valid/ready FIFO capturing in4 PLA decode vectors, with occupancy and a
// saturating accepted-word counter. Optional parity: PLA_IN4_RESP_PARITY_EN.
module pla_in4_resp_buffer
  import pla_in4_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [Z_WIDTH-1:0]         z_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [Z_WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
`ifdef PLA_IN4_RESP_PARITY_EN
  output logic                       out_parity,
`endif
  output logic [CNT_W-1:0]           accepted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [LVL_W-1:0]   level_reg, level_next;
  logic [CNT_W-1:0]   acc_reg, acc_next;
  logic [ENTRY_W-1:0] head_reg, head_next;
  logic [ENTRY_W-1:0] wdata;
  logic [ENTRY_W-1:0] rdata;
  logic               push;
  logic               pop;
  logic               mem_we;

`ifdef PLA_IN4_RESP_PARITY_EN
  assign wdata = {z_parity(z_in), z_in};
`else
  assign wdata = z_in;
`endif

  assign in_ready  = (level_reg != LVL_W'(DEPTH));
  assign out_valid = (level_reg != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign mem_we    = push & ~flush & rst_n;

  // Read port looks ahead at the next head slot so out_data can be a register.
  pla_in4_resp_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_reg),
    .wdata (wdata),
    .raddr (rd_ptr_next),
    .rdata (rdata)
  );

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;
    acc_next    = acc_reg;

    // The counter tracks presented handshakes, even in a flushed cycle.
    if (push && (acc_reg != {CNT_W{1'b1}})) begin
      acc_next = acc_reg + CNT_W'(1);
    end

    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = '0;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      if (push && !pop) begin
        level_next = level_reg + LVL_W'(1);
      end else if (!push && pop) begin
        level_next = level_reg - LVL_W'(1);
      end
    end
  end

  // Head register mirrors mem[rd_ptr]; a write into the next head slot bypasses.
  always_comb begin
    head_next = head_reg;
    if (mem_we && (wr_ptr_reg == rd_ptr_next)) begin
      head_next = wdata;
    end else if (pop || flush) begin
      head_next = rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      acc_reg    <= '0;
      head_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      level_reg  <= level_next;
      acc_reg    <= acc_next;
      head_reg   <= head_next;
    end
  end

  assign out_data = head_reg[Z_WIDTH-1:0];
  assign level    = level_reg;
  assign accepted = acc_reg;

`ifdef PLA_IN4_RESP_PARITY_EN
  assign out_parity = head_reg[Z_WIDTH];
`endif

endmodule

// File: tb/tb_pla_in4_resp_buffer.sv
// Randomized scoreboard bench for pla_in4_resp_buffer: a queue-based model
// tracks FIFO contents and the saturating counter; a monitor compares each cycle.
module tb_pla_in4_resp_buffer;
  import pla_in4_pkg::*;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 4;
  localparam int LVL_W   = $clog2(DEPTH+1);
  localparam int ACC_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               flush = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [Z_WIDTH-1:0] z_in = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [Z_WIDTH-1:0] out_data;
  logic [LVL_W-1:0]   level;
  logic [CNT_W-1:0]   accepted;
`ifdef PLA_IN4_RESP_PARITY_EN
  logic               out_parity;
`endif

  int checks = 0;
  int errors = 0;

  logic [Z_WIDTH-1:0] exp_q[$];
  int                 acc_model = 0;
  bit                 zero_data = 1'b1;

  always #5 clk = ~clk;

  pla_in4_resp_buffer #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .z_in       (z_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level),
`ifdef PLA_IN4_RESP_PARITY_EN
    .out_parity (out_parity),
`endif
    .accepted   (accepted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor/scoreboard: compare presented state, then apply this cycle's effects.
  always @(negedge clk) begin
    int  sz;
    int  exp_acc;
    bit  do_push;
    bit  do_pop;
    sz      = exp_q.size();
    exp_acc = (acc_model > ACC_MAX) ? ACC_MAX : acc_model;
    chk("out_valid", 32'(out_valid), 32'(sz != 0));
    chk("in_ready", 32'(in_ready), 32'(sz != DEPTH));
    chk("level", 32'(level), 32'(sz));
    chk("accepted", 32'(accepted), 32'(exp_acc));
    if (sz != 0) begin
      chk("out_data", 32'(out_data), 32'(exp_q[0]));
`ifdef PLA_IN4_RESP_PARITY_EN
      chk("out_parity", 32'(out_parity), 32'(^exp_q[0]));
`endif
    end else if (zero_data) begin
      chk("out_data_reset", 32'(out_data), 32'h0);
`ifdef PLA_IN4_RESP_PARITY_EN
      chk("out_parity_reset", 32'(out_parity), 32'h0);
`endif
    end

    if (!rst_n) begin
      exp_q.delete();
      acc_model = 0;
      zero_data = 1'b1;
    end else begin
      do_push = in_valid && (sz != DEPTH);
      do_pop  = (sz != 0) && out_ready;
      if (do_push) acc_model++;
      if (flush) begin
        exp_q.delete();
        zero_data = 1'b0;
        $display("flush (push dropped=%0d)", do_push);
      end else begin
        if (do_pop) begin
          $display("pop  z=%05h", exp_q[0]);
          void'(exp_q.pop_front());
        end
        if (do_push) begin
          exp_q.push_back(z_in);
          zero_data = 1'b0;
          $display("push z=%05h", z_in);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input string tag);
    int n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout actual=in_ready_low required=in_ready_high", tag);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [Z_WIDTH-1:0] z);
    in_valid = 1'b1;
    z_in     = z;
    wait_accept("send");
    in_valid = 1'b0;
  endtask

  initial begin
    bit stall;

    // Reset then idle
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();

    // Single word
    send(20'hABCDE);
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();

    // Fill and back-pressure
    for (int i = 1; i <= 4; i++) send(20'(i));
    in_valid = 1'b1;
    z_in     = 20'h00005;
    step();
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    wait_accept("held");
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 2) step();

    // Wrap with concurrent push/pop
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      z_in = 20'($urandom);
      step();
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;

    // Flush with a simultaneous push at level 3
    for (int i = 0; i < 3; i++) send(20'($urandom));
    in_valid = 1'b1;
    z_in     = 20'($urandom);
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    step();

    // Reset at level 2
    for (int i = 0; i < 2; i++) send(20'($urandom));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Randomized traffic, honouring the hold-while-stalled producer rule
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      stall = in_valid && !in_ready;
      @(posedge clk);
      #1;
      if (!stall) begin
        z_in     = 20'($urandom);
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      rst_n     = ($urandom_range(0, 150) != 0);
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    rst_n     = 1'b1;
    out_ready = 1'b0;
    step();

    // Counter saturation and parity examples
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) send(20'($urandom));
    out_ready = 1'b0;
    send(20'h00007);
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    send(20'h00003);
    step();
    out_ready = 1'b1;
    repeat (3) step();
    out_ready = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
